// File: rtl/acc_array.sv
// Accumulator array: LINES lanes each reduce TAPS signed products per beat. CONV layers
// accumulate over a channel group; SUB layers emit every beat. Define ACC_SAT_EN to saturate.
module acc_array #(
    parameter int LINES  = 5,
    parameter int TAPS   = 5,
    parameter int M_BW   = 16,
    parameter int AK_BW  = 20,
    parameter int CH_MAX = 16,
    parameter int CH_BW  = $clog2(CH_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   i_layer_state,
    input  logic [CH_BW-1:0]             i_num_ch,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [M_BW*TAPS*LINES-1:0]   i_mul_result,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [AK_BW*LINES-1:0]       o_acc_kernel
);

    // Headroom for the tap sum and the accumulate step before clamping back to AK_BW.
    localparam int LS_W = AK_BW + $clog2(TAPS) + 2;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_CONV = 2'd1,
        MODE_SUB  = 2'd2
    } mode_t;

    mode_t                    r_mode;
    mode_t                    mode_next;
    logic [CH_BW-1:0]         cnt;
    logic [CH_BW-1:0]         r_num;
    logic [CH_BW-1:0]         num_eff;
    logic [AK_BW*LINES-1:0]   acc;
    logic [AK_BW*LINES-1:0]   acc_next;
    logic [AK_BW*LINES-1:0]   lane_sum;
    logic signed [LS_W-1:0]   wide;
    logic signed [AK_BW-1:0]  lsat;
    logic signed [AK_BW-1:0]  base;
    logic                     fire;
    logic                     last;
    logic                     mode_change;

    function automatic logic signed [AK_BW-1:0] clamp(input logic signed [LS_W-1:0] x);
`ifdef ACC_SAT_EN
        logic signed [LS_W-1:0] hi;
        logic signed [LS_W-1:0] lo;
        hi = LS_W'({1'b0, {(AK_BW-1){1'b1}}});
        lo = -hi - LS_W'(1);
        if (x > hi)
            clamp = AK_BW'(hi);
        else if (x < lo)
            clamp = AK_BW'(lo);
        else
            clamp = AK_BW'(x);
`else
        clamp = AK_BW'(x);
`endif
    endfunction

    always_comb begin
        mode_next = MODE_IDLE;
        case (i_layer_state)
            3'b001, 3'b011, 3'b101: mode_next = MODE_CONV;
            3'b010, 3'b100:         mode_next = MODE_SUB;
            default:                mode_next = MODE_IDLE;
        endcase
    end

    assign mode_change = (mode_next != r_mode);
    assign o_ready     = (r_mode != MODE_IDLE) && (!o_valid || i_ready);
    assign fire        = i_valid && o_ready;

    // The first beat of a group decides its length from the live input, not the stale latch.
    always_comb begin
        num_eff = r_num;
        if (cnt == '0)
            num_eff = (i_num_ch == '0) ? CH_BW'(1) : i_num_ch;
    end

    assign last = (cnt == num_eff - CH_BW'(1));

    always_comb begin
        lane_sum = '0;
        acc_next = '0;
        wide     = '0;
        lsat     = '0;
        base     = '0;
        for (int unsigned l = 0; l < LINES; l++) begin
            wide = '0;
            for (int unsigned t = 0; t < TAPS; t++)
                wide = wide + LS_W'($signed(i_mul_result[(l*TAPS+t)*M_BW +: M_BW]));
            lsat = clamp(wide);
            lane_sum[l*AK_BW +: AK_BW] = lsat;
            base = (cnt == '0) ? '0 : $signed(acc[l*AK_BW +: AK_BW]);
            acc_next[l*AK_BW +: AK_BW] = clamp(LS_W'(base) + LS_W'(lsat));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= MODE_IDLE;
            cnt          <= '0;
            r_num        <= '0;
            acc          <= '0;
            o_valid      <= 1'b0;
            o_acc_kernel <= '0;
        end else begin
            r_mode <= mode_next;
            if (o_valid && i_ready)
                o_valid <= 1'b0;
            if (fire) begin
                if (r_mode == MODE_SUB) begin
                    o_acc_kernel <= lane_sum;
                    o_valid      <= 1'b1;
                    cnt          <= '0;
                end else begin
                    if (cnt == '0)
                        r_num <= num_eff;
                    acc <= acc_next;
                    if (last) begin
                        o_acc_kernel <= acc_next;
                        o_valid      <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CH_BW'(1);
                    end
                end
            end
            // A beat taken on the switching edge still completes; only the partial group is dropped.
            if (mode_change) begin
                cnt <= '0;
                acc <= '0;
            end
        end
    end

endmodule
